// File: rtl/riscv_defs_pkg.sv
// riscv_defs: shared widths, reset/bubble constants and fetch FSM encoding
package riscv_defs;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls
module if_id_reg #(
  parameter int XLEN = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);
  logic [XLEN-1:0] pc_q;
  logic [31:0] instr_q;
  logic valid_q;
  // bubble beats load; with neither asserted the contents are held
  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      if (rst) pc_q <= '0;
    end else if (load_i) begin
      pc_q <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end
  assign pc_o = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, halt FSM, fetch counter and IF/ID register
module fetch_unit
  import riscv_defs::*;
#(
  parameter int XLEN = riscv_defs::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_defs::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_instr_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [31:0]     if_id_instr_o,
  output logic            if_id_valid_o,
  output logic            halted_o,
  output logic [31:0]     fetch_count_o
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc, redirect_tgt;
  logic [31:0] cnt_q, cnt_d;
  logic load, bubble;
  assign pc_inc = pc_q + XLEN'(4);
  assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
  // state, PC and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  end
  // next state with priority redirect > flush > stall > normal; HALTED only listens to redirect
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    load = 1'b0;
    bubble = 1'b0;
    if (redirect_valid_i) begin
      state_d = RUN;
      pc_d = redirect_tgt;
      bubble = 1'b1;
    end else if (state_q == RUN) begin
      if (flush_i) begin
        bubble = 1'b1;
        pc_d = stall_i ? pc_q : pc_inc;
      end else if (!stall_i) begin
        if (imem_instr_i != '0) begin
          load = 1'b1;
          pc_d = pc_inc;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end else begin
          state_d = HALTED;
          bubble = 1'b1;
        end
      end
    end
  end
  if_id_reg #(.XLEN(XLEN), .NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .bubble_i(bubble),
    .pc_i(pc_q),
    .instr_i(imem_instr_i),
    .pc_o(if_id_pc_o),
    .instr_o(if_id_instr_o),
    .valid_o(if_id_valid_o)
  );
  assign imem_addr_o = pc_q;
  assign if_id_pc4_o = if_id_pc_o + XLEN'(4);
  assign halted_o = (state_q == HALTED);
  assign fetch_count_o = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed values
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, stall_i, flush_i, redirect_valid_i;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_instr_i;
  logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o, fetch_count_o;
  logic if_id_valid_o, halted_o;
  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr_i = mem[imem_addr_o[5:2]];

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o(imem_addr_o),
    .imem_instr_i(imem_instr_i),
    .if_id_pc_o(if_id_pc_o),
    .if_id_pc4_o(if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o),
    .halted_o(halted_o),
    .fetch_count_o(fetch_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = (i == 8) ? 32'h0 : (32'hA000_0000 | 32'(i));
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    step();
    step();
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(if_id_valid_o), 32'd0);
    chk("rst_instr", if_id_instr_o, 32'h13);
    chk("rst_ifpc", if_id_pc_o, 32'h0);
    chk("rst_halt", 32'(halted_o), 32'd0);
    chk("rst_cnt", fetch_count_o, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("run_pc%0d", i), if_id_pc_o, 32'(4 * i));
      chk($sformatf("run_instr%0d", i), if_id_instr_o, 32'hA000_0000 | 32'(i));
      chk($sformatf("run_valid%0d", i), 32'(if_id_valid_o), 32'd1);
      chk($sformatf("run_cnt%0d", i), fetch_count_o, 32'(i + 1));
    end
    chk("run_pc4", if_id_pc4_o, 32'h20);
    step();
    chk("halt_flag", 32'(halted_o), 32'd1);
    chk("halt_addr", imem_addr_o, 32'h20);
    chk("halt_cnt", fetch_count_o, 32'd8);
    chk("halt_valid", 32'(if_id_valid_o), 32'd0);
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    chk("halt_sf_addr", imem_addr_o, 32'h20);
    chk("halt_sf_flag", 32'(halted_o), 32'd1);
    stall_i = 1'b0;
    step();
    chk("halt_f_addr", imem_addr_o, 32'h20);
    chk("halt_f_valid", 32'(if_id_valid_o), 32'd0);
    chk("halt_f_cnt", fetch_count_o, 32'd8);
    flush_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h4;
    step();
    chk("unhalt_flag", 32'(halted_o), 32'd0);
    chk("unhalt_addr", imem_addr_o, 32'h4);
    chk("unhalt_valid", 32'(if_id_valid_o), 32'd0);
    redirect_valid_i = 1'b0;
    step();
    chk("restart_pc", if_id_pc_o, 32'h4);
    chk("restart_cnt", fetch_count_o, 32'd9);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_addr%0d", i), imem_addr_o, 32'h8);
      chk($sformatf("stall_ifpc%0d", i), if_id_pc_o, 32'h4);
      chk($sformatf("stall_instr%0d", i), if_id_instr_o, 32'hA000_0001);
      chk($sformatf("stall_cnt%0d", i), fetch_count_o, 32'd9);
    end
    stall_i = 1'b0;
    step();
    chk("resume_ifpc", if_id_pc_o, 32'h8);
    chk("resume_cnt", fetch_count_o, 32'd10);
    chk("resume_addr", imem_addr_o, 32'hC);
    flush_i = 1'b1;
    step();
    chk("flush_valid", 32'(if_id_valid_o), 32'd0);
    chk("flush_instr", if_id_instr_o, 32'h13);
    chk("flush_addr", imem_addr_o, 32'h10);
    chk("flush_cnt", fetch_count_o, 32'd10);
    flush_i = 1'b0; stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h13;
    step();
    chk("redir_addr", imem_addr_o, 32'h10);
    chk("redir_instr", if_id_instr_o, 32'h13);
    chk("redir_valid", 32'(if_id_valid_o), 32'd0);
    chk("redir_cnt", fetch_count_o, 32'd10);
    stall_i = 1'b0; redirect_valid_i = 1'b0;
    step();
    chk("post_redir_pc", if_id_pc_o, 32'h10);
    chk("post_redir_valid", 32'(if_id_valid_o), 32'd1);
    chk("post_redir_cnt", fetch_count_o, 32'd11);
    chk("midrst_pre", imem_addr_o, 32'h14);
    rst = 1'b1; stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    chk("midrst_addr", imem_addr_o, 32'h0);
    chk("midrst_valid", 32'(if_id_valid_o), 32'd0);
    chk("midrst_cnt", fetch_count_o, 32'd0);
    chk("midrst_instr", if_id_instr_o, 32'h13);
    rst = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0;
    step();
    chk("after_rst_ifpc", if_id_pc_o, 32'h0);
    chk("after_rst_cnt", fetch_count_o, 32'd1);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step();
    chk("wrap_tgt", imem_addr_o, 32'hFFFF_FFFC);
    redirect_valid_i = 1'b0;
    step();
    chk("wrap_ifpc", if_id_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4_o, 32'h0);
    chk("wrap_addr", imem_addr_o, 32'h0);
    chk("wrap_cnt", fetch_count_o, 32'd2);
    flush_i = 1'b1; stall_i = 1'b1;
    step();
    chk("fs_addr", imem_addr_o, 32'h0);
    chk("fs_valid", 32'(if_id_valid_o), 32'd0);
    chk("fs_cnt", fetch_count_o, 32'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
